// File: rtl/edf_fifo_sched.sv
// edf_fifo_sched: earliest-deadline-first read scheduler over NUM_Q FIFOs with a valid/ready egress offer.
// Define EDF_SCHED_RR_TIE_EN to break equal-deadline ties round-robin instead of lowest index.
module edf_fifo_sched #(
  parameter int NUM_Q = 4,
  parameter int DL_W  = 16,
  parameter int QID_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sch_en,
  input  logic [NUM_Q-1:0]        q_empty,
  input  logic [NUM_Q*DL_W-1:0]   q_head_dl,
  output logic [NUM_Q-1:0]        q_rd_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [QID_W-1:0]        out_qid,
  output logic [DL_W-1:0]         out_dl,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, OFFER, POP, SETTLE} state_t;
  state_t            r_state;
  logic [NUM_Q-1:0]  r_rd_en;
  logic              r_valid;
  logic              r_busy;
  logic [QID_W-1:0]  r_qid;
  logic [DL_W-1:0]   r_dl;
  logic              w_any;
  logic [QID_W-1:0]  w_qid;
  logic [DL_W-1:0]   w_dl;
  logic [DL_W-1:0]   w_cand;
  logic [DL_W-1:0]   w_diff;
  int                w_j;
`ifdef EDF_SCHED_RR_TIE_EN
  logic [QID_W-1:0]  r_ptr;
`endif
  // Strict wrap-aware compare: the first queue in search order keeps a tie.
  always_comb begin
    w_any  = 1'b0;
    w_qid  = '0;
    w_dl   = '0;
    w_cand = '0;
    w_diff = '0;
    w_j    = 0;
    for (int k = 0; k < NUM_Q; k++) begin
`ifdef EDF_SCHED_RR_TIE_EN
      w_j = (int'(r_ptr) + 1 + k) % NUM_Q;
`else
      w_j = k;
`endif
      w_cand = q_head_dl[w_j*DL_W +: DL_W];
      w_diff = w_cand - w_dl;
      if (!q_empty[w_j] && (!w_any || w_diff[DL_W-1])) begin
        w_any = 1'b1;
        w_qid = QID_W'(w_j);
        w_dl  = w_cand;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rd_en <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_qid   <= '0;
      r_dl    <= '0;
`ifdef EDF_SCHED_RR_TIE_EN
      r_ptr   <= QID_W'(NUM_Q-1);
`endif
    end else begin
      case (r_state)
        IDLE, SETTLE: begin
          r_rd_en <= '0;
          if (sch_en && w_any) begin
            r_state <= OFFER;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_qid   <= w_qid;
            r_dl    <= w_dl;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        OFFER: if (out_ready) begin
          r_state <= POP;
          r_valid <= 1'b0;
          r_rd_en <= NUM_Q'(1) << r_qid;
        end
        POP: begin
          r_state <= SETTLE;
          r_rd_en <= '0;
`ifdef EDF_SCHED_RR_TIE_EN
          r_ptr   <= r_qid;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign q_rd_en   = r_rd_en;
  assign out_valid = r_valid;
  assign out_qid   = r_qid;
  assign out_dl    = r_dl;
  assign busy      = r_busy;
endmodule
